// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze controller: rings on alarm-time rise, snoozes on key, auto-offs after RING_TIMEOUT ticks.
// All outputs registered or decoded from registered state, one-edge reaction; no backpressure (pulse inputs only).
module alarm_ring_ctrl #(
    parameter logic [5:0] RING_TIMEOUT  = 6'd60,
    parameter logic [8:0] SNOOZE_SEC    = 9'd300,
    parameter logic [1:0] MAX_SNOOZE    = 2'd3,
    parameter logic [3:0] K_SNOOZE      = 4'b0100,
    parameter logic [3:0] K_CONFIRM     = 4'b1000,
    parameter logic [2:0] S_ALARMTUNING = 3'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       reach_alarm_time,
    input  logic       alarm_enable,
    input  logic [2:0] sys_status,
    input  logic [3:0] neg_keys_filtered,
    output logic       ring_active,
    output logic       buzzer_en,
    output logic       snooze_active,
    output logic [8:0] snooze_remain,
    output logic [1:0] snooze_count,
    output logic       missed_alarm
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t     state;
    logic       reach_d;
    logic [5:0] ring_sec;
    logic       beep_phase;
    logic       rise;
    logic       key_confirm;
    logic       key_snooze;

    assign rise        = reach_alarm_time & ~reach_d;
    assign key_confirm = (neg_keys_filtered == K_CONFIRM);
    assign key_snooze  = (neg_keys_filtered == K_SNOOZE);

    assign ring_active   = (state == RING);
    assign snooze_active = (state == SNOOZE);
    assign buzzer_en     = ring_active & beep_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            reach_d       <= 1'b0;
            ring_sec      <= 6'd0;
            beep_phase    <= 1'b0;
            snooze_remain <= 9'd0;
            snooze_count  <= 2'd0;
            missed_alarm  <= 1'b0;
        end else begin
            reach_d      <= reach_alarm_time;
            missed_alarm <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise && alarm_enable && sys_status != S_ALARMTUNING) begin
                        state      <= RING;
                        ring_sec   <= 6'd0;
                        beep_phase <= 1'b1;
                    end
                end
                RING: begin
                    // Disable and confirm outrank snooze, which outranks the timeout tick.
                    if (!alarm_enable || key_confirm) begin
                        state         <= IDLE;
                        ring_sec      <= 6'd0;
                        beep_phase    <= 1'b0;
                        snooze_remain <= 9'd0;
                        snooze_count  <= 2'd0;
                    end else if (key_snooze && snooze_count < MAX_SNOOZE) begin
                        state         <= SNOOZE;
                        snooze_remain <= SNOOZE_SEC;
                        snooze_count  <= snooze_count + 2'd1;
                    end else if (tick_1hz) begin
                        if (ring_sec == RING_TIMEOUT - 6'd1) begin
                            state         <= IDLE;
                            missed_alarm  <= 1'b1;
                            ring_sec      <= 6'd0;
                            beep_phase    <= 1'b0;
                            snooze_remain <= 9'd0;
                            snooze_count  <= 2'd0;
                        end else begin
                            ring_sec   <= ring_sec + 6'd1;
                            beep_phase <= ~beep_phase;
                        end
                    end
                end
                SNOOZE: begin
                    if (!alarm_enable || key_confirm) begin
                        state         <= IDLE;
                        ring_sec      <= 6'd0;
                        beep_phase    <= 1'b0;
                        snooze_remain <= 9'd0;
                        snooze_count  <= 2'd0;
                    end else if (tick_1hz) begin
                        if (snooze_remain == 9'd1) begin
                            state         <= RING;
                            snooze_remain <= 9'd0;
                            ring_sec      <= 6'd0;
                            beep_phase    <= 1'b1;
                        end else if (snooze_remain != 9'd0) begin
                            snooze_remain <= snooze_remain - 9'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with hand-computed expectations.
module tb_alarm_ring_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       reach_alarm_time;
    logic       alarm_enable;
    logic [2:0] sys_status;
    logic [3:0] neg_keys_filtered;
    logic       ring_active;
    logic       buzzer_en;
    logic       snooze_active;
    logic [8:0] snooze_remain;
    logic [1:0] snooze_count;
    logic       missed_alarm;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] KS = 4'b0100;
    localparam logic [3:0] KC = 4'b1000;
    localparam logic [3:0] KX = 4'b0010;

    alarm_ring_ctrl dut (
        .clk(clk),
        .rst(rst),
        .tick_1hz(tick_1hz),
        .reach_alarm_time(reach_alarm_time),
        .alarm_enable(alarm_enable),
        .sys_status(sys_status),
        .neg_keys_filtered(neg_keys_filtered),
        .ring_active(ring_active),
        .buzzer_en(buzzer_en),
        .snooze_active(snooze_active),
        .snooze_remain(snooze_remain),
        .snooze_count(snooze_count),
        .missed_alarm(missed_alarm)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    task automatic press(input logic [3:0] k);
        neg_keys_filtered = k;
        step();
        neg_keys_filtered = 4'd0;
    endtask

    task automatic trigger();
        reach_alarm_time = 1'b1;
        step();
        reach_alarm_time = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; reach_alarm_time = 1'b0;
        alarm_enable = 1'b0; sys_status = 3'd0; neg_keys_filtered = 4'd0;
        step(); step();
        check("rst_ring", ring_active, 0);
        check("rst_buzz", buzzer_en, 0);
        check("rst_snz", snooze_active, 0);
        check("rst_remain", snooze_remain, 0);
        check("rst_count", snooze_count, 0);
        check("rst_missed", missed_alarm, 0);

        // Ring and dismiss
        rst = 1'b0; alarm_enable = 1'b1;
        step();
        reach_alarm_time = 1'b1;
        step();
        check("ring_entry", ring_active, 1);
        check("buzz_entry", buzzer_en, 1);
        reach_alarm_time = 1'b0;
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        check("beep1", buzzer_en, 0);
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        check("beep2", buzzer_en, 1);
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        check("beep3", buzzer_en, 0);
        press(KX);
        check("other_key", ring_active, 1);
        press(KC);
        check("confirm_idle", ring_active, 0);
        check("confirm_cnt", snooze_count, 0);

        // Gating
        sys_status = 3'd5;
        trigger();
        check("gate_tuning", ring_active, 0);
        sys_status = 3'd0; alarm_enable = 1'b0;
        trigger();
        check("gate_disable", ring_active, 0);
        alarm_enable = 1'b1;
        press(KS);
        check("idle_key", snooze_active, 0);
        reach_alarm_time = 1'b1;
        step();
        check("held_ring", ring_active, 1);
        press(KC);
        check("held_conf", ring_active, 0);
        step(); step();
        check("held_once", ring_active, 0);
        reach_alarm_time = 1'b0;
        step();

        // Timeout
        trigger();
        ticks(59);
        check("to_pre_ring", ring_active, 1);
        check("to_pre_missed", missed_alarm, 0);
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        check("to_idle", ring_active, 0);
        check("to_missed", missed_alarm, 1);
        step();
        check("to_missed_off", missed_alarm, 0);

        // Snooze cycle to the limit
        trigger();
        for (int s = 1; s <= 3; s++) begin
            press(KS);
            check("snz_act", snooze_active, 1);
            check("snz_remain", snooze_remain, 300);
            check("snz_count", snooze_count, s);
            ticks(1);
            check("snz_dec", snooze_remain, 299);
            ticks(298);
            check("snz_last", snooze_active, 1);
            ticks(1);
            check("snz_ring", ring_active, 1);
            check("snz_zero", snooze_remain, 0);
            check("snz_buzz", buzzer_en, 1);
        end
        press(KS);
        check("snz4_ring", ring_active, 1);
        check("snz4_cnt", snooze_count, 3);
        press(KC);
        check("snz_clear", snooze_count, 0);

        // Simultaneous events
        trigger();
        ticks(59);
        tick_1hz = 1'b1;
        press(KS);
        tick_1hz = 1'b0;
        check("sim_snz", snooze_active, 1);
        check("sim_missed", missed_alarm, 0);
        step();
        check("sim_missed2", missed_alarm, 0);
        press(KC);
        trigger();
        alarm_enable = 1'b0;
        press(KS);
        check("dis_idle", ring_active | snooze_active, 0);
        check("dis_cnt", snooze_count, 0);
        check("dis_missed", missed_alarm, 0);
        alarm_enable = 1'b1;

        // Reset mid-snooze, reach still high at release
        trigger();
        press(KS);
        ticks(180);
        check("mid_remain", snooze_remain, 120);
        rst = 1'b1; reach_alarm_time = 1'b1;
        step();
        check("mr_snz", snooze_active, 0);
        check("mr_remain", snooze_remain, 0);
        check("mr_count", snooze_count, 0);
        check("mr_ring", ring_active, 0);
        check("mr_buzz", buzzer_en, 0);
        rst = 1'b0;
        step();
        check("post_rst_rise", ring_active, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
